// File: rtl/packer_idle_timer.sv
// Saturating idle counter for the word packer; flags when a partial word has waited long enough.
// Only built when PACKER_TIMEOUT_EN is defined.
`ifdef PACKER_TIMEOUT_EN
module packer_idle_timer #(
  parameter int LGTIMEOUT = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic hit
);
  localparam logic [LGTIMEOUT-1:0] TMAX = '1;

  logic [LGTIMEOUT-1:0] timer;

  always_ff @(posedge clk) begin
    if (reset || clr)
      timer <= '0;
    else if (en && timer != TMAX)
      timer <= timer + LGTIMEOUT'(1);
  end

  assign hit = (timer == TMAX);
endmodule
`endif

// File: rtl/fifo_word_packer.sv
// Drains a byte FIFO and packs bytes big-endian into NB-byte words on a valid/ready stream.
// Define PACKER_TIMEOUT_EN to also emit partial words after an idle timeout.
module fifo_word_packer #(
  parameter int BW = 8,
  parameter int LGNB = 2
`ifdef PACKER_TIMEOUT_EN
  , parameter int LGTIMEOUT = 6
`endif
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_empty,
  input  logic [BW-1:0]               i_data,
  output logic                        o_rd,
  input  logic                        i_flush,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [(1<<LGNB)*BW-1:0]     o_data,
  output logic [LGNB:0]               o_bytes
);
  localparam int NB = 1 << LGNB;
  localparam int WW = NB * BW;
  localparam int CW = LGNB + 1;
  localparam logic [CW-1:0] FULL = CW'(NB);

  logic [WW-1:0] acc;
  logic [CW-1:0] count;
  logic          flush_pend;
  logic          out_free;
  logic          rd;
  logic          flush_req;
  logic          timeout_hit;
  logic          emit;

  // Keeps lanes 0..n-1 (lane 0 is the most significant byte).
  function automatic logic [WW-1:0] lane_mask(input logic [CW-1:0] n);
    logic [WW-1:0] m;
    m = '0;
    for (int l = 0; l < NB; l++)
      if (l < int'(n)) m[WW-1-l*BW -: BW] = '1;
    return m;
  endfunction

  function automatic logic [WW-1:0] lane_put(input logic [WW-1:0] a,
                                             input logic [CW-1:0] n,
                                             input logic [BW-1:0] b);
    logic [WW-1:0] r;
    r = a;
    for (int l = 0; l < NB; l++)
      if (l == int'(n)) r[WW-1-l*BW -: BW] = b;
    return r;
  endfunction

  assign out_free  = !o_valid || i_ready;
  assign rd        = !i_reset && !i_empty && (count != FULL || out_free);
  assign o_rd      = rd;
  assign flush_req = i_flush || flush_pend;
  assign emit      = out_free && (count != '0) &&
                     (count == FULL || flush_req || timeout_hit);

`ifdef PACKER_TIMEOUT_EN
  packer_idle_timer #(
    .LGTIMEOUT(LGTIMEOUT)
  ) u_idle_timer (
    .clk  (i_clk),
    .reset(i_reset),
    .clr  (rd || emit || count == '0),
    .en   (count != '0 && !rd),
    .hit  (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // A byte read in the emitting cycle always opens the next word, so the
  // emitted word is a snapshot of the accumulator before this edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      acc        <= '0;
      count      <= '0;
      flush_pend <= 1'b0;
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_bytes    <= '0;
    end else if (emit) begin
      o_data     <= acc & lane_mask(count);
      o_bytes    <= count;
      o_valid    <= 1'b1;
      acc        <= rd ? lane_put(WW'(0), CW'(0), i_data) : WW'(0);
      count      <= rd ? CW'(1) : CW'(0);
      flush_pend <= 1'b0;
    end else begin
      if (o_valid && i_ready)
        o_valid <= 1'b0;
      if (rd) begin
        acc   <= lane_put(acc, count, i_data);
        count <= count + CW'(1);
      end
      if (i_flush && (count != '0 || rd))
        flush_pend <= 1'b1;
    end
  end
endmodule

// File: doc/fifo_word_packer.md
Name: fifo_word_packer

Overview:
- Downstream stage of the CPU-side synchronous byte FIFO: drains bytes through the FIFO's empty/read/data interface and packs them into NB-byte words for a valid/ready word stream (bus-master write path, debug capture).
- First byte read goes in the most significant byte lane (big-endian).
- Partial words are emitted on an explicit flush request, or after an idle timeout when that feature is compiled in.

Parameters:
- BW, 8, bits per FIFO entry.
- LGNB, 2, log2 of bytes per output word; NB = 1<<LGNB.
- LGTIMEOUT, 6, idle timeout is (1<<LGTIMEOUT)-1 cycles; only used with PACKER_TIMEOUT_EN.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  reset; synchronous, active-high; clock i_clk.
- i_empty  in  1  upstream FIFO empty; i_data is valid whenever low (asynchronous-read FIFO).
- i_data  in  BW  upstream FIFO head entry.
- o_rd  out  1  FIFO read strobe; asserted only when !i_empty.
- i_flush  in  1  single-cycle request to emit any partial word.
- o_valid  out  1  output word valid.
- i_ready  in  1  downstream accepts the word.
- o_data  out  NB*BW  packed word; unused low lanes are zero.
- o_bytes  out  LGNB+1  valid byte count, 1..NB, in o_data.

Behaviour:
- State:
  - Accumulator acc[NB*BW], count[LGNB:0] in 0..NB.
  - Output register (o_valid, o_data, o_bytes).
  - flush_pend, idle timer.
- out_free = !o_valid || i_ready.
- o_rd = !i_reset && !i_empty && (count<NB || out_free).
- Byte capture on o_rd:
  - Byte goes to lane count (lane 0 = bits [NB*BW-1 -: BW]); count increments.
  - If an emission occurs in the same cycle, the byte goes to lane 0 of the fresh accumulator and count becomes 1.
- emit = out_free && count!=0 && (count==NB || flush_req || timeout_hit).
  - flush_req = i_flush || flush_pend.
- On emit:
  - o_data <= acc with lanes >= count zeroed; o_bytes <= count; o_valid <= 1.
  - acc cleared; count <= (o_rd ? 1 : 0).
  - Emission snapshots the pre-cycle acc; a byte read in the emitting cycle always starts the next word.
- If o_valid && i_ready && !emit, then o_valid <= 0.
- o_data and o_bytes hold stable while o_valid && !i_ready.
- Full accumulator with output busy: o_rd=0 and the FIFO back-pressures naturally. No byte is ever dropped or duplicated.
- flush_pend:
  - Set on i_flush when emit is not possible this cycle and count!=0, or when a byte is read while count==0.
  - Cleared on emit.
  - A flush with count==0 and no byte read is a no-op.
- Throughput: one byte per cycle sustained; one word per NB cycles when i_ready is held high.
- Reset (any cycle, including mid-word or mid-handshake):
  - o_valid=0, o_data=0, o_bytes=0, count=0, acc=0, flush_pend=0, timer=0.
  - Accumulated bytes are discarded. o_rd=0 during reset.

Optional Feature:
- PACKER_TIMEOUT_EN defined:
  - Idle timer counts cycles with count!=0 and !o_rd; it resets to 0 on o_rd, on emit, or when count==0.
  - timeout_hit = (timer == (1<<LGTIMEOUT)-1); timer saturates there until emit.
- Undefined: no timer logic; timeout_hit=0; partial words leave only on flush.

Decomposition:
- No shared package: NB, lane width and count width are module localparams derived from BW/LGNB.
- One natural sub-module, packer_idle_timer (LGTIMEOUT-bit saturating counter with clear/enable), instantiated only under PACKER_TIMEOUT_EN.
- Lane-zeroing mask is a combinational function of count inside the top module.

Test Plan:
- Full word: FIFO holds 0x11,0x22,0x33,0x44, i_ready=1 -> o_rd high 4 cycles; next cycle o_valid=1, o_data=0x11223344, o_bytes=4.
- Back-pressure: 12 bytes 0x01..0x0C, i_ready=0 for 20 cycles -> first word 0x01020304 held stable; o_rd stops after byte 8 with count=4; on release words 0x05060708, 0x090A0B0C, no loss.
- Flush: bytes 0xAA,0xBB then i_flush -> o_data=0xAABB0000, o_bytes=2; flush with count=0 -> no o_valid.
- Flush with byte arriving in the same cycle as emit: count=3 (0x01,0x02,0x03), i_flush while 0x04 is read -> emits 0x01020300, o_bytes=3; next word starts with 0x04.
- Reset mid-word: count=2, o_valid=1 held, assert i_reset one cycle -> o_valid=0, count=0, o_rd=0 that cycle; subsequent bytes 0x55..0x58 -> 0x55565758.
- PACKER_TIMEOUT_EN, LGTIMEOUT=3: single byte 0x7E then FIFO empty -> emit exactly 7 idle cycles later, o_data=0x7E000000, o_bytes=1; without the macro, no emit in 100 cycles.
